// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared constants for the 7-segment scan controller.
// Holds the bus widths, register offsets, CTRL bit positions and the
// hex-to-segment glyph table (active-low, bit order {g,f,e,d,c,b,a}).
package seg_scan_ctrl_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    // Register offsets
    localparam logic [ADDR_W-1:0] OFS_DATA   = 12'h000;
    localparam logic [ADDR_W-1:0] OFS_MASK   = 12'h004;
    localparam logic [ADDR_W-1:0] OFS_CTRL   = 12'h008;
    localparam logic [ADDR_W-1:0] OFS_DPMASK = 12'h00C;

    // CTRL field positions
    localparam int unsigned CTRL_BRIGHT_LSB = 0;
    localparam int unsigned CTRL_BRIGHT_W   = 4;
    localparam int unsigned CTRL_DP_EN_BIT  = 4;
    localparam int unsigned CTRL_BLINK_BIT  = 5;

    // Glyphs for 0..F; entry 15 is listed first
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: register-write bus from the bridge to the scan controller.
//   addr  : bus offset
//   wen   : one-cycle write strobe
//   wdata : write data
// modport master drives the bus (bridge / bench), modport slave receives it.
interface seg_scan_ctrl_if;
    import seg_scan_ctrl_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;

    modport master (output addr, output wen, output wdata);
    modport slave  (input  addr, input  wen, input  wdata);

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to 7-segment (active-low) encoder.
//   i_nibble : value 0..F
//   o_seg_c  : {g,f,e,d,c,b,a}, 0 = segment lit
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner with per-digit mask,
// PWM brightness, decimal-point mask and optional blink.
//   clk    : single clock
//   rst_n  : asynchronous active-low reset
//   bus    : register-write bus (seg_scan_ctrl_if.slave)
//   dig_en : digit select, active-low, one-hot-zero (registered)
//   seg    : {dp,g,f,e,d,c,b,a}, active-low (registered)
// Build option: define SEG_SCAN_BLINK_EN to include the CTRL.BLINK feature.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 20000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        bus,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg
);

    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCAN_W    = $clog2(SCAN_DIV);
    localparam int unsigned DATA_BITS = 4 * NUM_DIGITS;

    logic [SCAN_W-1:0]        r_scan_cnt;
    logic [IDX_W-1:0]         r_digit_idx;
    logic [3:0]               r_pwm_cnt;
    logic [DATA_BITS-1:0]     r_data;
    logic [NUM_DIGITS-1:0]    r_mask;
    logic [NUM_DIGITS-1:0]    r_dpmask;
    logic [3:0]               r_bright;
    logic                     r_dp_en;
    logic [NUM_DIGITS-1:0]    r_dig_en;
    logic [7:0]               r_seg;

    logic                     w_wr_data, w_wr_mask, w_wr_ctrl, w_wr_dpmask;
    logic                     w_scan_wrap, w_frame_end;
    logic [SCAN_W-1:0]        w_scan_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [NUM_DIGITS-1:0]    w_sel;
    logic [3:0]               w_nibble;
    logic [6:0]               w_hex;
    logic                     w_blink_off;
    logic                     w_show;
    logic                     w_dp_on;
    logic [NUM_DIGITS-1:0]    w_dig_en_nxt;
    logic [7:0]               w_seg_nxt;

    // Register write decode
    assign w_wr_data   = bus.wen && (bus.addr == OFS_DATA);
    assign w_wr_mask   = bus.wen && (bus.addr == OFS_MASK);
    assign w_wr_ctrl   = bus.wen && (bus.addr == OFS_CTRL);
    assign w_wr_dpmask = bus.wen && (bus.addr == OFS_DPMASK);

    // Scan counter / digit index next state
    always_comb begin
        w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
        w_frame_end = 1'b0;
        w_scan_nxt  = r_scan_cnt + SCAN_W'(1);
        w_idx_nxt   = r_digit_idx;
        if (w_scan_wrap) begin
            w_scan_nxt = '0;
            if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                w_idx_nxt   = '0;
                w_frame_end = 1'b1;
            end else begin
                w_idx_nxt = r_digit_idx + IDX_W'(1);
            end
        end
    end

    // One-hot select of the current digit and its nibble
    always_comb begin
        w_sel    = '0;
        w_nibble = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_nibble = r_data[4*i +: 4];
            end
        end
    end

    seg_hex_decode u_hex (
        .i_nibble (w_nibble),
        .o_seg_c  (w_hex)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic               r_ctrl_blink;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_lit;
    logic [BLINK_W-1:0] w_blink_cnt_nxt;
    logic               w_blink_lit_nxt;

    // Blink phase: dark half first, toggling every BLINK_FRAMES frames;
    // counters held at zero while BLINK is clear so re-arming starts dark.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_lit_nxt = r_blink_lit;
        if (!r_ctrl_blink) begin
            w_blink_cnt_nxt = '0;
            w_blink_lit_nxt = 1'b0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                w_blink_cnt_nxt = '0;
                w_blink_lit_nxt = ~r_blink_lit;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_blink <= 1'b0;
            r_blink_cnt  <= '0;
            r_blink_lit  <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl_blink <= bus.wdata[CTRL_BLINK_BIT];
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_lit <= w_blink_lit_nxt;
        end
    end

    assign w_blink_off = r_ctrl_blink && !r_blink_lit;
`else
    // Blink parameter and CTRL bit have no function in this build
    logic w_unused_blink_cfg;
    assign w_unused_blink_cfg = (BLINK_FRAMES == 0) ^ bus.wdata[CTRL_BLINK_BIT] ^ w_frame_end;
    assign w_blink_off        = 1'b0;
`endif

    // Output image for the current slot; blanked digits drive all segments off
    always_comb begin
        w_show       = (|(r_mask & w_sel)) && (r_pwm_cnt <= r_bright) && !w_blink_off;
        w_dp_on      = r_dp_en && (|(r_dpmask & w_sel));
        w_dig_en_nxt = '1;
        w_seg_nxt    = 8'hFF;
        if (w_show) begin
            w_dig_en_nxt = ~w_sel;
            w_seg_nxt    = {~w_dp_on, w_hex};
        end
    end

    // Counters, registers and both outputs share one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= '0;
            r_data      <= '0;
            r_mask      <= '1;
            r_dpmask    <= '0;
            r_bright    <= 4'hF;
            r_dp_en     <= 1'b0;
            r_dig_en    <= '1;
            r_seg       <= 8'hFF;
        end else begin
            r_scan_cnt  <= w_scan_nxt;
            r_digit_idx <= w_idx_nxt;
            r_pwm_cnt   <= r_pwm_cnt + 4'd1;
            if (w_wr_data)   r_data   <= bus.wdata[DATA_BITS-1:0];
            if (w_wr_mask)   r_mask   <= bus.wdata[NUM_DIGITS-1:0];
            if (w_wr_dpmask) r_dpmask <= bus.wdata[NUM_DIGITS-1:0];
            if (w_wr_ctrl) begin
                r_bright <= bus.wdata[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
                r_dp_en  <= bus.wdata[CTRL_DP_EN_BIT];
            end
            r_dig_en <= w_dig_en_nxt;
            r_seg    <= w_seg_nxt;
        end
    end

    assign dig_en = r_dig_en;
    assign seg    = r_seg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl
// (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2). One frame is 16 clocks and
// the PWM counter period is also 16, so every digit slot sees a fixed
// 4-value PWM window starting with digit 0 at pwm 0..3.
module tb_seg_scan_ctrl;

    localparam int unsigned ND = 4;

    typedef struct {
        string      name;
        logic [11:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0][3:0] exp_dig;   // per digit slot, index = digit
        logic [3:0][7:0] exp_seg;
    } vec_t;

    localparam logic [3:0][3:0] DIG_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][3:0] DIG_D0  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    localparam logic [3:0][3:0] DIG_M5  = {4'b1111, 4'b1011, 4'b1111, 4'b1110};

    logic            clk;
    logic            rst_n;
    logic [ND-1:0]   dig_en;
    logic [7:0]      seg;
    int              k;          // posedges since reset release
    int              n_checks;
    int              n_err;
    vec_t            vecs[$];

    seg_scan_ctrl_if bus_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .dig_en (dig_en),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    // Stop one clock before a posedge that lands on k%16==0
    task automatic wait_frame();
        while ((k % 16) != 15) tick();
    endtask

    task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wen   = 1'b1;
        tick();
        bus_if.wen   = 1'b0;
    endtask

    task automatic add_vec(input string n, input logic [11:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0][3:0] ed,
                           input logic [3:0][7:0] es);
        vec_t v;
        v.name = n; v.addr = a; v.wen = w; v.wdata = d;
        v.exp_dig = ed; v.exp_seg = es;
        vecs.push_back(v);
    endtask

    // Write lands on the frame-start edge; the next 16 clocks show one frame
    task automatic apply_vec(input vec_t v);
        int d;
        wait_frame();
        bus_if.addr  = v.addr;
        bus_if.wdata = v.wdata;
        bus_if.wen   = v.wen;
        tick();
        bus_if.wen   = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            d = j >> 2;
            check($sformatf("%s_dig%0d", v.name, d), 32'(dig_en), 32'(v.exp_dig[d]));
            check($sformatf("%s_seg%0d", v.name, d), 32'(seg), 32'(v.exp_seg[d]));
        end
    endtask

    initial begin
        int dark;
        int lit;
        n_checks = 0;
        n_err    = 0;
        k        = 0;
        rst_n        = 1'b0;
        bus_if.addr  = '0;
        bus_if.wen   = 1'b0;
        bus_if.wdata = '0;

        add_vec("idle",    12'h000, 1'b0, 32'h0,        DIG_ALL, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
        add_vec("scan",    12'h000, 1'b1, 32'h0000_4321, DIG_ALL, {8'h99, 8'hB0, 8'hA4, 8'hF9});
        add_vec("bad_ofs", 12'h010, 1'b1, 32'hFFFF_FFFF, DIG_ALL, {8'h99, 8'hB0, 8'hA4, 8'hF9});
        add_vec("mask",    12'h004, 1'b1, 32'h0000_0005, DIG_M5,  {8'hFF, 8'hB0, 8'hFF, 8'hF9});
        add_vec("mask_all",12'h004, 1'b1, 32'hFFFF_FFFF, DIG_ALL, {8'h99, 8'hB0, 8'hA4, 8'hF9});
        add_vec("pwm",     12'h008, 1'b1, 32'h0000_0003, DIG_D0,  {8'hFF, 8'hFF, 8'hFF, 8'hF9});
        add_vec("dpmask",  12'h00C, 1'b1, 32'h0000_0002, DIG_D0,  {8'hFF, 8'hFF, 8'hFF, 8'hF9});
        add_vec("dp",      12'h008, 1'b1, 32'h0000_001F, DIG_ALL, {8'h99, 8'hB0, 8'h24, 8'hF9});
        add_vec("hex",     12'h000, 1'b1, 32'h0000_0AF8, DIG_ALL, {8'hC0, 8'h88, 8'h0E, 8'h80});
        add_vec("dp_off",  12'h008, 1'b1, 32'h0000_000F, DIG_ALL, {8'hC0, 8'h88, 8'h8E, 8'h80});

        // Outputs idle while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dig", 32'(dig_en), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        rst_n = 1'b1;

        // First edge after release selects digit 0
        tick();
        check("first_dig", 32'(dig_en), 32'hE);
        check("first_seg", 32'(seg), 32'hC0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Blink: state now DATA=0AF8, MASK=F, BRIGHT=15, DP off
        wait_frame();
        write_reg(12'h008, 32'h0000_002F);
`ifdef SEG_SCAN_BLINK_EN
        dark = 0;
        for (int j = 0; j < 32; j++) begin
            tick();
            if (dig_en == 4'hF && seg == 8'hFF) dark++;
        end
        check("blink_dark1", 32'(dark), 32'd32);
        lit = 0;
        for (int j = 0; j < 32; j++) begin
            tick();
            if (dig_en != 4'hF) lit++;
        end
        check("blink_lit1", 32'(lit), 32'd32);
        dark = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (dig_en == 4'hF && seg == 8'hFF) dark++;
        end
        check("blink_dark2", 32'(dark), 32'd16);
        // Clearing BLINK mid-dark shows the digits on the next edge
        write_reg(12'h008, 32'h0000_000F);
        tick();
        check("blink_clear", 32'(dig_en != 4'hF), 32'd1);
`else
        lit = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            if (dig_en != 4'hF) lit++;
        end
        check("noblink_lit", 32'(lit), 32'd64);
        write_reg(12'h008, 32'h0000_000F);
`endif

        // Reset while digit 2 is shown
        wait_frame();
        while ((k % 16) != 9) tick();
        check("pre_rst_dig", 32'(dig_en), 32'hB);
        check("pre_rst_seg", 32'(seg), 32'h88);
        rst_n = 1'b0;
        #1;
        check("async_rst_dig", 32'(dig_en), 32'hF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            check($sformatf("post_rst_dig%0d", j >> 2), 32'(dig_en), 32'(DIG_ALL[j >> 2]));
            check($sformatf("post_rst_seg%0d", j >> 2), 32'(seg), 32'hC0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of 7-seg digits driven, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 20000: clk cycles each digit is selected, legal range >= 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period, legal range >= 1.
REQ-004 SHALL have ports: clk  in  1  single clock; reset is asynchronous and active-low, port rst_n  in  1.
REQ-005 SHALL have port addr  in  12  bus offset from bridge.
REQ-006 SHALL have port wen  in  1  write strobe, one cycle per write.
REQ-007 SHALL have port wdata  in  32  write data.
REQ-008 SHALL have port dig_en  out  NUM_DIGITS  digit select, active-low, one-hot-zero.
REQ-009 SHALL have port seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL decode offsets: 0x000 DATA (4 bits per digit, digit i = wdata[4i+3:4i]); 0x004 MASK (wdata[NUM_DIGITS-1:0], 1 = digit shown); 0x008 CTRL (bits[3:0] BRIGHT, bit4 DP_MASK_EN, bit5 BLINK); 0x00C DPMASK (wdata[NUM_DIGITS-1:0]). Other offsets are ignored.
REQ-011 SHALL update a register on the clk edge where wen=1 and the offset matches; the new value SHALL reach seg/dig_en no later than the second edge after the write.
REQ-012 SHALL run scan_cnt 0..SCAN_DIV-1; on wrap, digit_idx SHALL advance, and NUM_DIGITS-1 SHALL wrap to 0, completing one frame.
REQ-013 SHALL run a free 4-bit pwm_cnt; the current digit SHALL be driven only when pwm_cnt <= BRIGHT, so BRIGHT=15 gives 100% and BRIGHT=0 gives 1/16.
REQ-014 SHALL drive dig_en[digit_idx]=0 only when MASK[digit_idx]=1, the PWM gate is on and blink is not in its off phase; all other bits SHALL be 1.
REQ-015 SHALL encode the nibble as hex 0-F to segments a-g (0 -> seg[6:0]=7'b1000000, F -> 7'b0001110).
REQ-016 SHALL drive seg[7] (dp) to 0 only when DP_MASK_EN=1 and DPMASK[digit_idx]=1.
REQ-017 SHALL drive seg to 8'hFF whenever the current digit is blanked.
REQ-018 SHALL register seg and dig_en with no combinational path from inputs, and SHALL update both on the same edge so no ghosting occurs.
REQ-019 SHALL apply a write on the edge where digit_idx advances to the next scan slot.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear scan_cnt, digit_idx, pwm_cnt, blink counters, DATA, DPMASK and CTRL.BLINK, and SHALL set MASK to all ones, BRIGHT to 15 and DP_MASK_EN to 0.
REQ-021 During reset, dig_en SHALL be all ones and seg SHALL be 8'hFF.
REQ-022 Reset asserted mid-frame SHALL restart scanning at digit 0 on the first edge after release.

Configuration
REQ-023 With macro SEG_SCAN_BLINK_EN defined, CTRL.BLINK=1 SHALL blank all digits for BLINK_FRAMES frames, then show them for BLINK_FRAMES frames, repeating; clearing BLINK SHALL show digits immediately and reset the blink counters.
REQ-024 Without SEG_SCAN_BLINK_EN, the blink counters SHALL NOT exist, CTRL bit5 SHALL be ignored, and the display SHALL never blink.

Structure
REQ-025 A shared package SHALL hold the register offset constants (DATA, MASK, CTRL, DPMASK), the CTRL bit positions, and the 16-entry hex-to-segment table.
REQ-026 The hex-to-segment encoder SHALL be a sub-module, seg_hex_decode, instantiated once on the selected nibble.

Verification
REQ-027 Bench configuration SHALL be NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
REQ-028 Scan test: after reset, write DATA=32'h0000_4321 -> dig_en SHALL cycle 1110,1101,1011,0111 every 4 clks, with seg showing 1,2,3,4.
REQ-029 Mask test: write MASK=4'b0101 -> digits 1 and 3 SHALL give dig_en=1111 and seg=8'hFF in their slots.
REQ-030 PWM test: write CTRL BRIGHT=3 -> dig_en SHALL be active for exactly 4 of each 16 cycles.
REQ-031 DP test: write CTRL=0x1F and DPMASK=4'b0010 -> seg[7]=0 only while digit 1 is selected.
REQ-032 Blink test: with SEG_SCAN_BLINK_EN defined, set BLINK -> digits SHALL be dark for 32 cycles and lit for 32 cycles, repeating; without the macro, digits SHALL stay lit.
REQ-033 Reset test: assert rst_n=0 while digit 2 is selected -> outputs SHALL go idle immediately; after release, digit 0 SHALL be selected and DATA SHALL read back as 0.
